serial_sub: RTL

//  Bit-serial subtractor: computes diff = a - b - bin over WIDTH clock cycles.

---
 rtl/serial_sub_pkg.sv | 13 +
 rtl/serial_sub_full_sub.sv | 18 +
 rtl/serial_sub.sv | 96 +++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Latency: n/a (types only).
// Backpressure: n/a.
package serial_sub_pkg;

  // Controller state encodings, fixed so they line up with the adder's controller
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Mirror of the full-adder cell: a borrow is needed when b (plus borrow-in) exceeds a
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per cycle, LSB first.
// Latency: start sampled at edge 0, result and one-cycle done after edge WIDTH.
// Backpressure: none; start is ignored while busy or in DONE, operands not re-latched.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             bit_d;
  logic             bit_bout;

  // Single subtractor cell shared across all bit positions; always fed the current LSBs
  full_sub u_full_sub (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (borrow),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // Controller, operand shift registers, borrow FF and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= bin;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // One bit step per edge; the result fills from the MSB end so it lands aligned
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          borrow <= bit_bout;
          diff   <= {bit_d, diff[WIDTH-1:1]};
          if (cnt == LAST) begin
            bout  <= bit_bout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
